aftab_dawu_store_sequencer: RTL and testbench

- Store-side counterpart of the DARU load path; this is the Data Alignment Write Unit (DAWU) sequencer.
- Takes a 1/2/4-byte store request from the AFTAB controller, checks alignment, and serialises the data onto the byte-wide memory write port (little-endian, one byte per accepted handshake).
- Reports completion, or a store-misaligned fault, back to the controller/trap logic.
- Sits between the AFTAB datapath store operands and the memory interface.

---
 rtl/aftab_dawu_store_sequencer_if.sv | 27 ++
 rtl/aftab_dawu_store_sequencer.sv | 135 +++++++++++++
 tb/tb_aftab_dawu_store_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/aftab_dawu_store_sequencer_if.sv
// Bus bundle between the AFTAB controller/memory side and the DAWU store sequencer.
interface aftab_dawu_store_sequencer_if #(
  parameter int size = 32
);
  logic            startDAWU;
  logic [1:0]      nBytes;
  logic [size-1:0] addrIn;
  logic [size-1:0] dataIn;
  logic            checkMisalignedDAWU;
  logic            memReady;
  logic [size-1:0] addrOut;
  logic [7:0]      dataOut;
  logic            writeMem;
  logic            completeDAWU;
  logic            storeMisalignedFlag;
  logic            storeAccessFaultFlag;

  modport master (
    output startDAWU, nBytes, addrIn, dataIn, checkMisalignedDAWU, memReady,
    input  addrOut, dataOut, writeMem, completeDAWU, storeMisalignedFlag, storeAccessFaultFlag
  );

  modport slave (
    input  startDAWU, nBytes, addrIn, dataIn, checkMisalignedDAWU, memReady,
    output addrOut, dataOut, writeMem, completeDAWU, storeMisalignedFlag, storeAccessFaultFlag
  );
endinterface

// File: rtl/aftab_dawu_store_sequencer.sv
// DAWU store sequencer: serialises a 1/2/4-byte store onto a byte-wide write port, little-endian.
// Optional memReady timeout (FAULT_TO) is enabled by defining AFTAB_DAWU_TIMEOUT_EN.
module aftab_dawu_store_sequencer #(
  parameter int size = 32
`ifdef AFTAB_DAWU_TIMEOUT_EN
  , parameter int timeoutCycles = 15
`endif
) (
  input logic clk,
  input logic rst,
  aftab_dawu_store_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WRITE, DONE, FAULT, FAULT_TO} dawuStateT;

  dawuStateT       stateReg, stateNext;
  logic [1:0]      cntReg, cntNext;
  logic [1:0]      nBytesReg, nBytesNext;
  logic [size-1:0] addrReg, addrNext;
  logic [size-1:0] dataReg, dataNext;
  logic [size-1:0] addrOutReg, addrOutNext;
  logic [7:0]      dataOutReg, dataOutNext;
  logic            writeMemReg, writeMemNext;
  logic            completeReg, completeNext;
  logic            misalignedReg, misalignedNext;
  logic            misaligned;
  logic [1:0]      lastIdx;

`ifdef AFTAB_DAWU_TIMEOUT_EN
  localparam int WaitW = $clog2(timeoutCycles + 1);
  logic [WaitW-1:0] waitReg, waitNext;
  logic             accessFaultReg, accessFaultNext;
`endif

  assign misaligned = bus.checkMisalignedDAWU &
                      (((bus.nBytes == 2'b01) & bus.addrIn[0]) |
                       ((bus.nBytes == 2'b11) & (bus.addrIn[1:0] != 2'b00)));

  // Index of the final byte: byte/reserved -> 0, half -> 1, word -> 3.
  assign lastIdx = nBytesReg[0] ? {nBytesReg[1], 1'b1} : 2'b00;

  always_comb begin
    stateNext  = stateReg;
    cntNext    = cntReg;
    nBytesNext = nBytesReg;
    addrNext   = addrReg;
    dataNext   = dataReg;
`ifdef AFTAB_DAWU_TIMEOUT_EN
    waitNext   = waitReg;
`endif
    case (stateReg)
      IDLE: begin
        if (bus.startDAWU) begin
          addrNext   = bus.addrIn;
          dataNext   = bus.dataIn;
          nBytesNext = bus.nBytes;
          cntNext    = 2'd0;
`ifdef AFTAB_DAWU_TIMEOUT_EN
          waitNext   = '0;
`endif
          stateNext  = misaligned ? FAULT : WRITE;
        end
      end
      WRITE: begin
        if (bus.memReady) begin
          cntNext = cntReg + 2'd1;
          if (cntReg == lastIdx) stateNext = DONE;
`ifdef AFTAB_DAWU_TIMEOUT_EN
          waitNext = '0;
        end else if (waitReg == WaitW'(timeoutCycles - 1)) begin
          // This stall cycle is the timeoutCycles-th in a row.
          stateNext = FAULT_TO;
        end else begin
          waitNext = waitReg + 1'b1;
`endif
        end
      end
      default: stateNext = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    writeMemNext   = (stateNext == WRITE);
    addrOutNext    = (stateNext == WRITE) ? addrNext + size'(cntNext) : '0;
    dataOutNext    = (stateNext == WRITE) ? dataNext[{cntNext, 3'b000} +: 8] : 8'h00;
    completeNext   = stateNext inside {DONE, FAULT, FAULT_TO};
    misalignedNext = (stateNext == FAULT);
`ifdef AFTAB_DAWU_TIMEOUT_EN
    accessFaultNext = (stateNext == FAULT_TO);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg      <= IDLE;
      cntReg        <= '0;
      nBytesReg     <= '0;
      addrReg       <= '0;
      dataReg       <= '0;
      addrOutReg    <= '0;
      dataOutReg    <= '0;
      writeMemReg   <= 1'b0;
      completeReg   <= 1'b0;
      misalignedReg <= 1'b0;
`ifdef AFTAB_DAWU_TIMEOUT_EN
      waitReg        <= '0;
      accessFaultReg <= 1'b0;
`endif
    end else begin
      stateReg      <= stateNext;
      cntReg        <= cntNext;
      nBytesReg     <= nBytesNext;
      addrReg       <= addrNext;
      dataReg       <= dataNext;
      addrOutReg    <= addrOutNext;
      dataOutReg    <= dataOutNext;
      writeMemReg   <= writeMemNext;
      completeReg   <= completeNext;
      misalignedReg <= misalignedNext;
`ifdef AFTAB_DAWU_TIMEOUT_EN
      waitReg        <= waitNext;
      accessFaultReg <= accessFaultNext;
`endif
    end
  end

  assign bus.addrOut             = addrOutReg;
  assign bus.dataOut             = dataOutReg;
  assign bus.writeMem            = writeMemReg;
  assign bus.completeDAWU        = completeReg;
  assign bus.storeMisalignedFlag = misalignedReg;
`ifdef AFTAB_DAWU_TIMEOUT_EN
  assign bus.storeAccessFaultFlag = accessFaultReg;
`else
  assign bus.storeAccessFaultFlag = 1'b0;
`endif
endmodule

// File: tb/tb_aftab_dawu_store_sequencer.sv
// Directed bench for the DAWU store sequencer: vector table plus stall, reset-abort and timeout sequences.
module tb_aftab_dawu_store_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aftab_dawu_store_sequencer_if #(.size(32)) bus ();
  aftab_dawu_store_sequencer #(.size(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [1:0]       nb;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic             chk;
    logic             expMis;
    int               expN;
    logic [3:0][31:0] expAddr;
    logic [3:0][7:0]  expData;
  } vecT;

  vecT vecs[10];

  localparam logic [43:0] IdleOut = 44'h0;
  localparam logic [43:0] DoneOut = {1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0};
  localparam logic [43:0] MisOut  = {1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 8'h0};
  localparam logic [43:0] ToOut   = {1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 8'h0};

  function automatic logic [43:0] outs();
    return {bus.writeMem, bus.completeDAWU, bus.storeMisalignedFlag, bus.storeAccessFaultFlag,
            bus.addrOut, bus.dataOut};
  endfunction

  function automatic logic [43:0] wr(input logic [31:0] a, input logic [7:0] d);
    return {1'b1, 1'b0, 1'b0, 1'b0, a, d};
  endfunction

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("FAIL %s: got {wm,cmp,mis,acc,addr,data}=%h, required %h", name, act, req);
    end else begin
      $display("[TB] ok %s (%h)", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe one request with memReady high and follow it to completion.
  task automatic applyVec(input vecT v, input string tag);
    bus.nBytes              = v.nb;
    bus.addrIn              = v.addr;
    bus.dataIn              = v.data;
    bus.checkMisalignedDAWU = v.chk;
    bus.memReady            = 1'b1;
    bus.startDAWU           = 1'b1;
    tick();
    bus.startDAWU = 1'b0;
    bus.addrIn    = 32'hDEAD_BEEF;
    bus.dataIn    = 32'h5555_AAAA;
    if (v.expMis) begin
      check({tag, "_fault"}, outs(), MisOut);
    end else begin
      for (int k = 0; k < v.expN; k++) begin
        check($sformatf("%s_byte%0d", tag, k), outs(), wr(v.expAddr[k], v.expData[k]));
        tick();
      end
      check({tag, "_done"}, outs(), DoneOut);
    end
    tick();
    check({tag, "_idle"}, outs(), IdleOut);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nComplete;
    vecs[0] = '{2'b11, 32'h0000_0100, 32'hA1B2_C3D4, 1'b1, 1'b0, 4,
                {32'h103, 32'h102, 32'h101, 32'h100}, {8'hA1, 8'hB2, 8'hC3, 8'hD4}};
    vecs[1] = '{2'b01, 32'h0000_0203, 32'hA1B2_C3D4, 1'b1, 1'b1, 0, '0, '0};
    vecs[2] = '{2'b01, 32'h0000_0203, 32'hA1B2_C3D4, 1'b0, 1'b0, 2,
                {32'h0, 32'h0, 32'h204, 32'h203}, {8'h00, 8'h00, 8'hC3, 8'hD4}};
    vecs[3] = '{2'b00, 32'h0000_0007, 32'h0000_005A, 1'b1, 1'b0, 1,
                {32'h0, 32'h0, 32'h0, 32'h7}, {8'h00, 8'h00, 8'h00, 8'h5A}};
    vecs[4] = '{2'b10, 32'h0000_0013, 32'h9988_7766, 1'b1, 1'b0, 1,
                {32'h0, 32'h0, 32'h0, 32'h13}, {8'h00, 8'h00, 8'h00, 8'h66}};
    vecs[5] = '{2'b11, 32'h0000_0102, 32'h1122_3344, 1'b1, 1'b1, 0, '0, '0};
    vecs[6] = '{2'b11, 32'h0000_0102, 32'h1122_3344, 1'b0, 1'b0, 4,
                {32'h105, 32'h104, 32'h103, 32'h102}, {8'h11, 8'h22, 8'h33, 8'h44}};
    vecs[7] = '{2'b11, 32'hFFFF_FFFE, 32'hCAFE_F00D, 1'b0, 1'b0, 4,
                {32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE}, {8'hCA, 8'hFE, 8'hF0, 8'h0D}};
    vecs[8] = '{2'b01, 32'h0000_0202, 32'hAAAA_5511, 1'b1, 1'b0, 2,
                {32'h0, 32'h0, 32'h203, 32'h202}, {8'h00, 8'h00, 8'h55, 8'h11}};
    vecs[9] = '{2'b11, 32'h0000_0001, 32'h0102_0304, 1'b1, 1'b1, 0, '0, '0};

    // Reset, with a request and memReady asserted that must be ignored.
    rst                     = 1'b0;
    bus.startDAWU           = 1'b1;
    bus.nBytes              = 2'b11;
    bus.addrIn              = 32'h40;
    bus.dataIn              = 32'h1234_5678;
    bus.checkMisalignedDAWU = 1'b0;
    bus.memReady            = 1'b1;
    tick();
    tick();
    check("reset_state", outs(), IdleOut);
    bus.startDAWU = 1'b0;
    rst           = 1'b1;
    tick();
    check("post_reset_idle", outs(), IdleOut);

    for (int i = 0; i < 10; i++) applyVec(vecs[i], $sformatf("vec%0d", i));

    // Byte store stalled 3 cycles; a second strobe during the stall is dropped.
    bus.nBytes              = 2'b00;
    bus.addrIn              = 32'h40;
    bus.dataIn              = 32'h1234_5677;
    bus.checkMisalignedDAWU = 1'b1;
    bus.memReady            = 1'b0;
    bus.startDAWU           = 1'b1;
    tick();
    bus.startDAWU = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("stall_c%0d", c), outs(), wr(32'h40, 8'h77));
      bus.memReady  = (c == 4);
      bus.startDAWU = (c == 2);
      if (c == 2) begin
        bus.addrIn = 32'h80;
        bus.dataIn = 32'hFFFF_FFFF;
      end
      tick();
    end
    bus.startDAWU = 1'b0;
    check("stall_done", outs(), DoneOut);
    nComplete = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      nComplete += int'(bus.completeDAWU) + int'(bus.writeMem);
    end
    testsRun++;
    if (nComplete != 0) begin
      testsFailed++;
      $display("FAIL stall_no_second_txn: got %0d extra complete/write cycles, required 0", nComplete);
    end else begin
      $display("[TB] ok stall_no_second_txn");
    end

    // Reset pulled mid-store after the second byte, then a clean word store.
    bus.nBytes              = 2'b11;
    bus.addrIn              = 32'hFFFF_FFFC;
    bus.dataIn              = 32'h0BAD_F00D;
    bus.checkMisalignedDAWU = 1'b1;
    bus.memReady            = 1'b1;
    bus.startDAWU           = 1'b1;
    tick();
    bus.startDAWU = 1'b0;
    check("abort_b0", outs(), wr(32'hFFFF_FFFC, 8'h0D));
    tick();
    check("abort_b1", outs(), wr(32'hFFFF_FFFD, 8'hF0));
    tick();
    check("abort_b2", outs(), wr(32'hFFFF_FFFE, 8'hAD));
    rst = 1'b0;
    #1;
    check("abort_async_clear", outs(), IdleOut);
    tick();
    check("abort_hold", outs(), IdleOut);
    rst = 1'b1;
    tick();
    check("abort_no_complete", outs(), IdleOut);
    applyVec('{2'b11, 32'h0, 32'h0102_0304, 1'b1, 1'b0, 4,
               {32'h3, 32'h2, 32'h1, 32'h0}, {8'h01, 8'h02, 8'h03, 8'h04}}, "after_abort");

    // memReady stuck low.
    bus.nBytes              = 2'b00;
    bus.addrIn              = 32'h55;
    bus.dataIn              = 32'h0000_00EE;
    bus.checkMisalignedDAWU = 1'b0;
    bus.memReady            = 1'b0;
    bus.startDAWU           = 1'b1;
    tick();
    bus.startDAWU = 1'b0;
`ifdef AFTAB_DAWU_TIMEOUT_EN
    for (int c = 1; c <= 15; c++) begin
      check($sformatf("timeout_wait_c%0d", c), outs(), wr(32'h55, 8'hEE));
      tick();
    end
    check("timeout_fault", outs(), ToOut);
    tick();
    check("timeout_idle", outs(), IdleOut);
`else
    for (int c = 1; c <= 20; c++) begin
      check($sformatf("nowait_limit_c%0d", c), outs(), wr(32'h55, 8'hEE));
      bus.memReady = (c == 20);
      tick();
    end
    check("nowait_limit_done", outs(), DoneOut);
    tick();
    check("nowait_limit_idle", outs(), IdleOut);
    check("no_timeout_flag_ref", ToOut & 44'h0, outs() & 44'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
